// File: rtl/output_blk_if.sv
// output_blk_if: byte-stream push port of the UART transmit block.
// master = producer (core side), slave = output_blk.
interface output_blk_if;
  logic       write;
  logic [7:0] data_in;
  logic       full;
  logic       idle;

  modport master (
    output write,
    output data_in,
    input  full,
    input  idle
  );

  modport slave (
    input  write,
    input  data_in,
    output full,
    output idle
  );
endinterface

// File: rtl/output_blk.sv
// output_blk: byte FIFO feeding a UART transmitter (8N1, LSB first).
// Define OUTPUT_BLK_PARITY_EN for 8E1 frames with an even-parity bit.
module output_blk #(
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD       = 100_000,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  output_blk_if.slave bus,
  output logic        tx
);
  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef OUTPUT_BLK_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t state, state_nxt;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic             full_q, idle_q;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shift;
  logic             tx_nxt;
  logic             pop, shift_en;
  logic             wr_en, empty, baud_done;
`ifdef OUTPUT_BLK_PARITY_EN
  logic             par;
`endif

  assign bus.full  = full_q;
  assign bus.idle  = idle_q;

  // a write while full is dropped even if a pop frees a slot this cycle
  assign wr_en     = bus.write && !full_q;
  assign empty     = (count == '0);
  assign baud_done = (cnt == CNT_LAST);
  assign count_nxt = count + CW'(wr_en) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    pop       = 1'b0;
    shift_en  = 1'b0;
    tx_nxt    = 1'b1;
    unique case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        tx_nxt = 1'b0;
        if (baud_done) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = S_DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        tx_nxt = shift[0];
        if (baud_done) begin
          cnt_nxt  = '0;
          shift_en = 1'b1;
          idx_nxt  = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef OUTPUT_BLK_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`ifdef OUTPUT_BLK_PARITY_EN
      S_PARITY: begin
        tx_nxt = par;
        if (baud_done) begin
          cnt_nxt   = '0;
          state_nxt = S_STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        tx_nxt = 1'b1;
        if (baud_done) begin
          cnt_nxt = '0;
          // chain straight into the next start bit when data is waiting
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
      idle_q <= 1'b1;
      tx     <= 1'b1;
      shift  <= '0;
`ifdef OUTPUT_BLK_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      count  <= count_nxt;
      full_q <= (count_nxt == CNT_FULL);
      idle_q <= (count_nxt == '0) && (state_nxt == S_IDLE);
      tx     <= tx_nxt;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (pop) begin
        shift <= mem[rd_ptr];
`ifdef OUTPUT_BLK_PARITY_EN
        par   <= ^mem[rd_ptr];
`endif
      end else if (shift_en) begin
        shift <= {1'b0, shift[7:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.data_in;
  end
endmodule

// File: doc/output_blk.md
Name: output_blk

Overview:
Transmit-side counterpart of the host serial link. It accepts bytes from the accelerator core into a small FIFO and serialises them onto a UART TX line (8N1, LSB first). It sits between the result/readback path and the board TX pin and mirrors the receive block's byte-stream interface in the opposite direction.

Parameters:
FIFO_DEPTH, 4, byte FIFO entries; must be a power of 2 and at least 2
BAUD, 100_000, line rate in bits/s
CLK_FREQ, 100_000_000, clk frequency in Hz; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be at least 2)

Ports:
clk  input  1  system clock; all logic is on its rising edge
rst  input  1  synchronous, active-high reset
write  input  1  push data_in into the FIFO this cycle
data_in  input  8  byte to transmit
full  output  1  FIFO holds FIFO_DEPTH bytes; writes are dropped
idle  output  1  FIFO empty AND serialiser in IDLE; the line is quiet
tx  output  1  UART serial output, idle high

Behaviour:
- Reset (rst=1 at an edge): FIFO pointers and count cleared, FSM set to IDLE, baud counter and bit index set to 0. Outputs: tx=1, full=0, idle=1. Reset wins over every other event. Reset mid-frame aborts the frame: tx=1 from the next edge and the FIFO contents are lost.
- FIFO:
  - A write with full=0 stores data_in at the write pointer. A write with full=1 is ignored, even if a pop occurs in the same cycle.
  - A simultaneous write and pop on a non-full FIFO leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - full and idle are registered and reflect the count after the current edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop its head into an 8-bit shift register, clear the baud counter and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back frames with no extra idle bit). Otherwise go to IDLE.
- Baud counter: counts 0 to CLKS_PER_BIT-1, and the bit period ends on the terminal count. Width is $clog2(CLKS_PER_BIT).
- tx is driven from a register (glitch-free).
- Latency: with write at edge N into an empty, idle block, the FIFO is non-empty after N. The pop is at edge N+1 and tx falls after edge N+2.
- Frame length: 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity, see Optional Feature).
- An empty FIFO during a frame has no effect until STOP ends.
- The byte being serialised is held in the shift register and no longer occupies a FIFO slot. Sustained capacity is therefore FIFO_DEPTH+1 bytes.

Optional Feature:
Macro: OUTPUT_BLK_PARITY_EN
- Defined: adds state PARITY between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits, computed at pop time) for CLKS_PER_BIT cycles. The frame is 8E1, 11 bit periods.
- Undefined: no PARITY state or parity logic; the frame is 8N1, 10 bit periods.

Test Plan:
All scenarios use BAUD=10_000_000 and CLK_FREQ=100_000_000, giving CLKS_PER_BIT=10.
- Reset: hold rst for 3 cycles -> tx=1, full=0, idle=1. Release with no writes -> tx stays 1 for 100 cycles.
- Single byte: write 0xA5 once -> tx falls 2 cycles after the write edge, then is low 10 cycles. Data bits are 1,0,1,0,0,1,0,1 for 10 cycles each, then stop high 10 cycles. idle=1 one cycle after the stop period ends. Total 100 cycles (110 with parity, parity bit=0).
- Back-to-back: write 0x00 and 0xFF on consecutive cycles -> two frames with no gap between the stop of frame 1 and the start of frame 2. The sampled bytes match.
- Full/overflow: with the serialiser busy, write 5 bytes 0x11..0x15 at DEPTH=4 -> full=1 after the 4th write; 0x15 is dropped. Exactly 0x10 (in flight) then 0x11..0x14 appear on tx.
- Write while full plus pop in the same cycle: the pop cycle coincides with a write while full=1 -> the write is dropped and the count drops to 3.
- Reset mid-frame: assert rst during DATA bit 3 -> tx=1 on the next edge and idle=1. A subsequent write of 0x3C transmits correctly.
